// File: rtl/adder_operand_sequencer.sv
// Byte-serial feeder for a wide combinational adder: assembles a, b and cin
// from a byte stream, drives them for one settle cycle, then holds the captured sum.
module adder_operand_sequencer #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               cin_o,
    input  logic [WIDTH-1:0]   sum_i,
    input  logic               cout_i,
    output logic [WIDTH-1:0]   res_sum,
    output logic               res_cout,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COUNT_W-1:0] op_count
);

    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_C,
        EXEC,
        HOLD
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic             byte_xfer;
    logic             res_xfer;

    assign byte_xfer = in_valid && in_ready;
    assign res_xfer  = res_valid && res_ready;

    // in_ready is a registered flag: high in the LOAD states, low from the
    // cin transfer until the cycle after the result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            idx       <= '0;
            shadow_a  <= '0;
            shadow_b  <= '0;
            a_o       <= '0;
            b_o       <= '0;
            cin_o     <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD_A: begin
                    if (byte_xfer) begin
                        shadow_a[8*idx +: 8] <= in_data;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (byte_xfer) begin
                        shadow_b[8*idx +: 8] <= in_data;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= LOAD_C;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_C: begin
                    // Adder inputs change only here, so the adder sees one stable
                    // operand set for the whole EXEC cycle.
                    if (byte_xfer) begin
                        cin_o    <= in_data[0];
                        a_o      <= shadow_a;
                        b_o      <= shadow_b;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_sum   <= sum_i;
                    res_cout  <= cout_i;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_xfer) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        in_ready  <= 1'b1;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    idx       <= '0;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench for adder_operand_sequencer: directed and random operations,
// with a second instance at COUNT_W=4 to exercise counter wrap.
module tb_adder_operand_sequencer;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              res_ready;

    logic              in_ready, cin_o, cout_i, res_cout, res_valid;
    logic [WIDTH-1:0]  a_o, b_o, sum_i, res_sum;
    logic [15:0]       op_count;

    logic              in_ready4, cin4, cout4, rcout4, rvalid4;
    logic [WIDTH-1:0]  a4, b4, sum4, rsum4;
    logic [3:0]        opc4;

    // Combinational adder models feeding each instance
    assign {cout_i, sum_i} = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, cin_o};
    assign {cout4, sum4}   = {1'b0, a4} + {1'b0, b4} + {{WIDTH{1'b0}}, cin4};

    adder_operand_sequencer #(.WIDTH(WIDTH), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .a_o(a_o), .b_o(b_o), .cin_o(cin_o),
        .sum_i(sum_i), .cout_i(cout_i), .res_sum(res_sum), .res_cout(res_cout),
        .res_valid(res_valid), .res_ready(res_ready), .op_count(op_count)
    );

    adder_operand_sequencer #(.WIDTH(WIDTH), .COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .a_o(a4), .b_o(b4), .cin_o(cin4),
        .sum_i(sum4), .cout_i(cout4), .res_sum(rsum4), .res_cout(rcout4),
        .res_valid(rvalid4), .res_ready(res_ready), .op_count(opc4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   n_xfer = 0;
    bit   cnt_pending = 0;
    int   acc_cycle = 0;

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result transfer and checks the
    // counters on the cycle after each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_xfer      = 0;
            cnt_pending = 0;
        end else begin
            if (cnt_pending) begin
                chk("op_count", op_count, n_xfer % 65536);
                chk("op_count_w4", opc4, n_xfer % 16);
                cnt_pending = 0;
            end
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", res_sum);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("res_sum", res_sum, e.sum);
                    chk("res_cout", res_cout, e.cout);
                    chk("a_o", a_o, e.a);
                    chk("b_o", b_o, e.b);
                    chk("cin_o", cin_o, e.cin);
                end
                n_xfer++;
                cnt_pending = 1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, need 1", t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cycle = cycle;
        in_valid  = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] cbyte,
                           input logic [31:0] esum, input logic ecout, input int gap);
        exp_t e;
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gap);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], gap);
        e.a = a; e.b = b; e.cin = cbyte[0]; e.sum = esum; e.cout = ecout;
        sbq.push_back(e);
        send_byte(cbyte, gap);
        chk("res_valid_exec", res_valid, 1'b0);
        @(posedge clk); #1;
        chk("res_valid_latency", res_valid, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || res_valid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, need 0", sbq.size());
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_a_o"}, a_o, 0);
        chk({tag, "_b_o"}, b_o, 0);
        chk({tag, "_cin_o"}, cin_o, 0);
        chk({tag, "_res_sum"}, res_sum, 0);
        chk({tag, "_res_cout"}, res_cout, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_op_count"}, op_count, 0);
        chk({tag, "_op_count_w4"}, opc4, 0);
    endtask

    initial begin
        logic [31:0] ra, rb, rs;
        logic [7:0]  rc;
        logic        rco;
        int          prev_acc;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Carry ripples through every bit
        res_ready = 1'b1;
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 8'h00, 32'h0000_0000, 1'b1, 0);
        // Little-endian assembly, cin from bit 0 only
        send_op(32'h1234_5678, 32'h8765_4321, 8'hFF, 32'h9999_999A, 1'b0, 0);
        drain();

        // Gappy input, result held with downstream stalled
        res_ready = 1'b0;
        send_op(32'h0000_FFFF, 32'h0000_0001, 8'h01, 32'h0001_0001, 1'b0, 1);
        repeat (5) begin
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_res_sum", res_sum, 32'h0001_0001);
            chk("hold_res_cout", res_cout, 1'b0);
            chk("hold_op_count", op_count, 16'd2);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_op_count", op_count, 16'd3);
        chk("release_res_valid", res_valid, 1'b0);
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1'b1);

        // Reset in the middle of loading b
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h80, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        rst_n = 1'b0;
        #2;
        check_cleared("midload_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_midload_reset", in_ready, 1'b1);
        send_op(32'h8000_0000, 32'h8000_0000, 8'h00, 32'h0000_0000, 1'b1, 0);
        drain();

        // Fresh start for the back-to-back run
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 8'($urandom_range(0, 255));
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + {32'd0, rc[0]};
            send_op(ra, rb, rc, rs, rco, 0);
            if (i > 0) chk("op_period", acc_cycle - prev_acc, 11);
            prev_acc = acc_cycle;
        end
        drain();
        @(posedge clk); #1;
        chk("final_op_count", op_count, 16'd1000);
        chk("final_op_count_w4", opc4, 4'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
- Upstream feeder stage for the combinational 32-bit full adder.
- Accepts a byte stream over a valid/ready handshake and assembles operands a, b and cin.
- Drives the assembled operands onto the adder inputs, captures the adder's sum/cout one cycle later, and presents the result on a valid/ready output port.
- Lets a narrow serial test or IO path exercise the wide adder. The adder's inputs change only once per operation.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of 8 and at least 8.
- COUNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  operand byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a byte this cycle.
- a_o  output  WIDTH  operand a to adder.
- b_o  output  WIDTH  operand b to adder.
- cin_o  output  1  carry-in to adder.
- sum_i  input  WIDTH  adder sum, combinational from a_o/b_o/cin_o.
- cout_i  input  1  adder carry-out.
- res_sum  output  WIDTH  captured sum.
- res_cout  output  1  captured carry-out.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts the result.
- op_count  output  COUNT_W  number of results accepted downstream (wraps).

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = LOAD_A, byte index = 0.
  - a_o, b_o, cin_o, res_sum, res_cout, op_count and both shadow registers = 0.
  - res_valid = 0.
  - in_ready is 1 from the first cycle after rst_n deasserts.
- A byte transfer occurs on any rising edge with in_valid and in_ready both high. A result transfer occurs on any rising edge with res_valid and res_ready both high.
- Byte order is little-endian: the first byte of a field is bits [7:0].
- NB = WIDTH/8. The byte index counts 0..NB-1 and resets to 0 on each field change.
- State machine:
  - LOAD_A: in_ready = 1. Each transfer writes shadow_a[8*idx +: 8]. The transfer at idx = NB-1 moves to LOAD_B.
  - LOAD_B: in_ready = 1. Same as LOAD_A, writing shadow_b. The transfer at idx = NB-1 moves to LOAD_C.
  - LOAD_C: in_ready = 1. One transfer, on which:
    - cin_o <= in_data[0]; in_data[7:1] are ignored.
    - a_o <= shadow_a and b_o <= shadow_b, loaded together with the completed b byte, i.e. using the full shadow_b.
    - Next state EXEC.
  - EXEC: in_ready = 0. Lasts one cycle. At its end: res_sum <= sum_i, res_cout <= cout_i, res_valid <= 1, next state HOLD.
  - HOLD: in_ready = 0. res_sum, res_cout and res_valid are held stable. On a result transfer: res_valid <= 0, op_count <= op_count + 1 (modulo 2^COUNT_W), next state LOAD_A. in_ready returns to 1 in the following cycle.
- Latency: the cin byte is accepted at edge N and res_valid is high after edge N+1. Minimum operation period is 2*NB + 3 cycles when in_valid and res_ready are held high.
- a_o, b_o and cin_o change only on the LOAD_C transfer edge and hold until the next operation's LOAD_C transfer. The adder therefore has a full EXEC cycle to settle.
- in_valid low in any LOAD state stalls with no state change. Gaps between bytes are unlimited.
- res_ready may be high before res_valid rises. The transfer then completes on the first edge where res_valid is high, giving a 1-cycle HOLD.
- Bytes presented during EXEC/HOLD are not accepted (in_ready = 0). The upstream must hold them.
- Reset asserted mid-load or in HOLD discards the partial operation and any pending result. No result is emitted.
- No overflow flag. Carry-out is reported only via res_cout, and wrap-around of the sum is the adder's behaviour.

Test Plan:
- Bytes FF FF FF FF, 01 00 00 00, 00 -> a_o = 0xFFFFFFFF, b_o = 0x00000001, cin_o = 0; res_sum = 0x00000000, res_cout = 1; res_valid rises 1 cycle after the cin byte's acceptance edge.
- Bytes 78 56 34 12, 21 43 65 87, FF -> a_o = 0x12345678, b_o = 0x87654321, cin_o = 1 (bit 0 only); res_sum = 0x9999999A, res_cout = 0.
- in_valid toggled every other cycle during load, plus res_ready held low 5 cycles in HOLD -> result unchanged and stable; in_ready = 0 throughout HOLD; op_count increments by exactly 1 when res_ready rises.
- rst_n pulsed low after 6 bytes accepted -> all outputs 0 and state LOAD_A; next 9 bytes (00 00 00 80, 00 00 00 80, 00) yield res_sum = 0, res_cout = 1.
- 1000 random back-to-back operations with in_valid and res_ready tied high -> every result equals a + b + cin (33-bit compare); op_count = 1000 mod 2^COUNT_W; each operation takes 11 cycles.
- COUNT_W = 4, 17 operations -> op_count reads 15 after the 15th result transfer, wraps to 0 after the 16th, reads 1 after the 17th.
